// File: rtl/scan_seq_pkg.sv
// Shared types, constants and lane-order helpers for the scan sequencer.
// The helpers honour the optional lane mask (macro SCAN_SEQ_LANE_MASK_EN).
package scan_seq_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [SEL_W-1:0] first_lane(input logic [LANES-1:0] mask);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    function automatic logic has_next(input logic [LANES-1:0] mask,
                                      input logic [SEL_W-1:0] cur);
        logic r;
        r = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i] && (i > int'(cur))) r = 1'b1;
        end
        return r;
    endfunction

    // Lowest enabled lane above cur; only meaningful when has_next() is true.
    function automatic logic [SEL_W-1:0] next_lane(input logic [LANES-1:0] mask,
                                                   input logic [SEL_W-1:0] cur);
        logic [SEL_W-1:0] r;
        r = cur;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) r = SEL_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a sweep controller (master) and the sequencer (slave).
// lane_mask exists only when SCAN_SEQ_LANE_MASK_EN is defined.
interface scan_sequencer_if
    import scan_seq_pkg::*;
#(
    parameter int DWELL_W = 4
);
    logic               start;
    logic               stop;
    logic               cont;
    logic [DWELL_W-1:0] dwell;
`ifdef SCAN_SEQ_LANE_MASK_EN
    logic [LANES-1:0]   lane_mask;
`endif
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               busy;
    logic               done;

    modport master (
`ifdef SCAN_SEQ_LANE_MASK_EN
        output lane_mask,
`endif
        output start, stop, cont, dwell,
        input  sel, sel_valid, busy, done
    );

    modport slave (
`ifdef SCAN_SEQ_LANE_MASK_EN
        input  lane_mask,
`endif
        input  start, stop, cont, dwell,
        output sel, sel_valid, busy, done
    );
endinterface

// File: rtl/scan_sequencer_dwell_timer.sv
// Per-lane dwell counter: counts 0..limit while enabled, expire flags the last cycle.
// Reloaded to zero on every lane change, so it never wraps even at the maximum limit.
module dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expire
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)        cnt_d = '0;
        else if (enable) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == limit);
endmodule

// File: rtl/scan_sequencer.sv
// Lane scan sequencer: steps a 2-bit lane select through the lanes, dwelling dwell+1 cycles each.
// Optional lane skipping is enabled with macro SCAN_SEQ_LANE_MASK_EN.
module scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    scan_sequencer_if.slave   bus
);
    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [LANES-1:0]   mask_q, mask_d;
    logic [LANES-1:0]   start_mask;
    logic               tmr_load, tmr_en, tmr_expire;

`ifdef SCAN_SEQ_LANE_MASK_EN
    assign start_mask = bus.lane_mask;
`else
    assign start_mask = '1;
`endif

    dwell_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .enable (tmr_en),
        .limit  (dwell_q),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dwell_d     = dwell_q;
        cont_d      = cont_q;
        mask_d      = mask_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_load    = 1'b1;
                sel_d       = '0;
                sel_valid_d = 1'b0;
                busy_d      = 1'b0;
                if (bus.start && !bus.stop && (|start_mask)) begin
                    state_d     = RUN;
                    sel_d       = first_lane(start_mask);
                    sel_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    dwell_d     = bus.dwell;
                    cont_d      = bus.cont;
                    mask_d      = start_mask;
                end
            end
            RUN: begin
                // Abort wins over expiry so a stop on the final cycle never pulses done.
                if (bus.stop) begin
                    state_d     = IDLE;
                    sel_d       = '0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    tmr_load    = 1'b1;
                end else if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (has_next(mask_q, sel_q)) begin
                        sel_d = next_lane(mask_q, sel_q);
                    end else if (cont_q) begin
                        sel_d  = first_lane(mask_q);
                        done_d = 1'b1;
                    end else begin
                        state_d     = DONE;
                        sel_d       = '0;
                        sel_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                tmr_load = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                sel_d       = '0;
                sel_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dwell_q     <= dwell_d;
            cont_q      <= cont_d;
            mask_q      <= mask_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL provide parameter DWELL_W, default 4, width of the dwell-count input and internal dwell counter.
REQ-002 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  begin a sweep, sampled in IDLE only.
REQ-005 SHALL provide port stop  input  1  abort the sweep, returning to IDLE.
REQ-006 SHALL provide port cont  input  1  continuous mode: restart the sweep after the last lane instead of finishing.
REQ-007 SHALL provide port dwell  input  DWELL_W  cycles-per-lane minus one, latched on accepted start.
REQ-008 SHALL provide port sel  output  2  lane select code, drives the downstream 2-to-4 one-hot decoder select input.
REQ-009 SHALL provide port sel_valid  output  1  sel is meaningful this cycle.
REQ-010 SHALL provide port busy  output  1  high in RUN and DONE.
REQ-011 SHALL provide port done  output  1  one-cycle pulse at sweep completion.

Function
REQ-012 SHALL register all outputs; there is no combinational path from any input to any output.
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 IDLE: on an edge with start=1 and stop=0, SHALL move to RUN with sel=first lane, counter=0, and dwell and cont latched (dwell_q, cont_q); sel_valid=1 from that edge.
REQ-015 RUN: SHALL hold each lane for dwell_q+1 cycles; counter increments each cycle, and when counter==dwell_q the lane expires.
REQ-016 On lane expiry with a later lane remaining, SHALL advance sel to the next lane in ascending order and clear the counter.
REQ-017 On expiry of the last lane with cont_q=0, SHALL move to DONE: sel_valid=0, done=1, sel=00.
REQ-018 On expiry of the last lane with cont_q=1, SHALL stay in RUN: sel=first lane, counter cleared, done=1 for that one cycle, sel_valid held at 1.
REQ-019 DONE: SHALL return to IDLE on the next edge, with done=0 and busy=0.
REQ-020 stop=1 in RUN or DONE SHALL force IDLE on the next edge without a done pulse; stop takes priority over lane expiry.
REQ-021 start in RUN or DONE SHALL be ignored; start and stop both high in IDLE SHALL leave the block in IDLE.
REQ-022 dwell=0 SHALL give one cycle per lane; the maximum dwell (2^DWELL_W-1) SHALL give 2^DWELL_W cycles per lane with no counter overflow.
REQ-023 Changes on the dwell or cont inputs during RUN SHALL have no effect until the next accepted start.

Reset
REQ-024 rst=1 SHALL asynchronously force IDLE, sel=00, sel_valid=0, busy=0, done=0, counter=0, dwell_q=0, cont_q=0, including mid-sweep.
REQ-025 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Configuration
REQ-026 Macro SCAN_SEQ_LANE_MASK_EN defined: SHALL add input lane_mask[3:0], latched on start; lanes whose mask bit is 0 are skipped; "first" and "last" lane refer to the lowest and highest enabled lane; start with mask 4'b0000 SHALL be ignored.
REQ-027 Macro SCAN_SEQ_LANE_MASK_EN undefined: no lane_mask port; all four lanes are visited, 0 to 3.

Structure
REQ-028 Package scan_seq_pkg SHALL hold the state enumeration and constants LANES=4 and SEL_W=2.
REQ-029 The dwell counter SHALL be a sub-module dwell_timer (load, enable, expire output), instantiated once.

Verification
REQ-030 Reset: assert rst mid-sweep -> all outputs 0 immediately, before the next clock edge.
REQ-031 dwell=0, cont=0, start pulse -> sel 0,1,2,3 on four consecutive cycles with sel_valid=1, then done=1 with sel_valid=0 for one cycle, then busy=0.
REQ-032 dwell=2, cont=0 -> each lane held 3 cycles, 12 sel_valid cycles total, then done for one cycle.
REQ-033 dwell=1, cont=1 -> sequence 0,0,1,1,2,2,3,3,0,...; done high on the cycle sel returns to 0; sel_valid never drops.
REQ-034 stop asserted while sel=2 -> next edge enters IDLE, sel_valid=0, no done; start and stop asserted together in IDLE -> remains IDLE.
REQ-035 With SCAN_SEQ_LANE_MASK_EN, lane_mask=4'b1010, dwell=0 -> sel 1 then 3, then done; lane_mask=4'b0000 -> start ignored, busy stays 0.
